// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer: polyphonic sawtooth voice engine with per-voice envelope.
// Scans every voice once per sample period and emits one saturated mix.
module poly_voice_mixer #(
  parameter int NUM_VOICES   = 256,
  parameter int PHASE_W      = 32,
  parameter int SAMPLE_W     = 24,
  parameter int VEL_W        = 7,
  parameter int ENV_W        = 8,
  parameter int ATTACK_STEP  = 255,
  parameter int RELEASE_STEP = 1,
  parameter int SAMPLE_DIV   = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_SPI_flag,
  input  logic                              i_SPI_note_status,
  input  logic [7:0]                        i_SPI_voice_index,
  input  logic [PHASE_W-1:0]                i_SPI_tuning_code,
  input  logic [VEL_W-1:0]                  i_SPI_velocity,
  output logic signed [SAMPLE_W-1:0]        o_mixed_sample,
  output logic                              o_sample_valid,
  output logic [$clog2(NUM_VOICES):0]       o_active_voices
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int CNT_W  = IDX_W + 1;
  localparam int ACC_W  = SAMPLE_W + IDX_W;
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int PROD_W = SAMPLE_W + VEL_W + ENV_W + 2;
  localparam int SHIFT  = VEL_W + ENV_W;
  localparam int EMAX   = (2 ** ENV_W) - 1;

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(IDX_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(IDX_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] scan_q;
  logic [1:0]       drain_q;

  logic [NUM_VOICES-1:0]              gate_q;
  logic [NUM_VOICES-1:0][PHASE_W-1:0] tune_q;
  logic [NUM_VOICES-1:0][PHASE_W-1:0] phase_q;
  logic [NUM_VOICES-1:0][VEL_W-1:0]   vel_q;
  logic [NUM_VOICES-1:0][ENV_W-1:0]   env_q;

  logic               cur_gate;
  logic [PHASE_W-1:0] cur_tune;
  logic [PHASE_W-1:0] cur_phase;
  logic [VEL_W-1:0]   cur_vel;
  logic [ENV_W-1:0]   cur_env;

  logic [31:0]         env_w;
  logic [31:0]         env_up;
  logic [ENV_W-1:0]    env_nx;
  logic                active;
  logic [PHASE_W-1:0]  phase_nx;
  logic [SAMPLE_W-1:0] saw;

  logic             cmd_hit;
  logic [IDX_W-1:0] cmd_idx;
  logic             scan_we;

  logic                       p1_vld;
  logic                       p1_act;
  logic signed [SAMPLE_W-1:0] p1_saw;
  logic [VEL_W-1:0]           p1_vel;
  logic [ENV_W-1:0]           p1_env;

  logic                     p2_vld;
  logic                     p2_act;
  logic signed [PROD_W-1:0] p2_prod;

  logic signed [PROD_W-1:0] m_saw;
  logic signed [PROD_W-1:0] m_vel;
  logic signed [PROD_W-1:0] m_env;
  logic signed [PROD_W-1:0] m_prod;

  logic signed [ACC_W-1:0]    contrib;
  logic signed [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]           cnt_q;
  logic signed [SAMPLE_W-1:0] sat;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (div_q == '0) state_d = S_SCAN;
      S_SCAN:  if (scan_q == IDX_W'(NUM_VOICES - 1)) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == 2'd2) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      scan_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= (div_q == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_q + 1'b1;
      scan_q  <= (state_q == S_SCAN) ? scan_q + 1'b1 : '0;
      drain_q <= (state_q == S_DRAIN) ? drain_q + 2'd1 : 2'd0;
    end
  end

  assign cur_gate  = gate_q[scan_q];
  assign cur_tune  = tune_q[scan_q];
  assign cur_phase = phase_q[scan_q];
  assign cur_vel   = vel_q[scan_q];
  assign cur_env   = env_q[scan_q];

  always_comb begin
    env_w  = 32'(cur_env);
    env_up = env_w + 32'(ATTACK_STEP);
    env_nx = '0;
    if (cur_gate) begin
      env_nx = (env_up > 32'(EMAX)) ? ENV_W'(EMAX) : env_up[ENV_W-1:0];
    end else if (env_w > 32'(RELEASE_STEP)) begin
      env_nx = ENV_W'(env_w - 32'(RELEASE_STEP));
    end
  end

  assign active   = cur_gate | (env_nx != '0);
  assign phase_nx = active ? cur_phase + cur_tune : cur_phase;
  // Saw is taken from the phase before this frame's advance.
  assign saw = {~cur_phase[PHASE_W-1], cur_phase[PHASE_W-2 -: SAMPLE_W-1]};

  assign scan_we = (state_q == S_SCAN);
  assign cmd_hit = i_SPI_flag &&
                   ({1'b0, i_SPI_voice_index} < 9'(NUM_VOICES));
  assign cmd_idx = i_SPI_voice_index[IDX_W-1:0];

  // Command writes follow the scan write so a note-on's phase clear wins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gate_q  <= '0;
      tune_q  <= '0;
      phase_q <= '0;
      vel_q   <= '0;
      env_q   <= '0;
    end else begin
      if (scan_we) begin
        phase_q[scan_q] <= phase_nx;
        env_q[scan_q]   <= env_nx;
      end
      if (cmd_hit) begin
        gate_q[cmd_idx] <= i_SPI_note_status;
        if (i_SPI_note_status) begin
          tune_q[cmd_idx]  <= i_SPI_tuning_code;
          vel_q[cmd_idx]   <= i_SPI_velocity;
          phase_q[cmd_idx] <= '0;
        end
      end
    end
  end

  assign m_saw  = PROD_W'(p1_saw);
  assign m_vel  = PROD_W'({1'b0, p1_vel});
  assign m_env  = PROD_W'({1'b0, p1_env});
  assign m_prod = m_saw * m_vel * m_env;

  assign contrib = ACC_W'(p2_prod >>> SHIFT);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      p1_vld  <= 1'b0;
      p1_act  <= 1'b0;
      p1_saw  <= '0;
      p1_vel  <= '0;
      p1_env  <= '0;
      p2_vld  <= 1'b0;
      p2_act  <= 1'b0;
      p2_prod <= '0;
    end else begin
      p1_vld  <= scan_we;
      p1_act  <= scan_we & active;
      p1_saw  <= saw;
      p1_vel  <= active ? cur_vel : '0;
      p1_env  <= env_nx;
      p2_vld  <= p1_vld;
      p2_act  <= p1_act;
      p2_prod <= m_prod;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_IDLE && state_d == S_SCAN) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (p2_vld) begin
      acc_q <= acc_q + contrib;
      cnt_q <= cnt_q + CNT_W'(p2_act);
    end
  end

  always_comb begin
    sat = SAMPLE_W'(acc_q);
    if (acc_q > SMAX) sat = SAMPLE_W'(SMAX);
    else if (acc_q < SMIN) sat = SAMPLE_W'(SMIN);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_mixed_sample  <= '0;
      o_sample_valid  <= 1'b0;
      o_active_voices <= '0;
    end else begin
      o_sample_valid <= (state_q == S_OUT);
      if (state_q == S_OUT) begin
        o_mixed_sample  <= sat;
        o_active_voices <= cnt_q;
      end
    end
  end

endmodule
